dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the CPU data-memory port: serves word loads/stores issued by the core
//  (address, write data, write strobe) from an internal word RAM, with programmable wait states.
//  Replaces the zero-latency combinational data memory so the core can be verified against a stalling memory.
//  Sits between the core's data port and the top-level memory map; ready doubles as the core stall release.
// PARAMETERS
//  DEPTH_LOG2   8  log2 of RAM depth in 32-bit words (256 words = 1 KiB)
//  WAIT_CYCLES  2  extra cycles between request acceptance and response; legal range 0..15
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst          in   1   synchronous reset, active-high
//  req          in   1   request valid; level, held by requester until ready
//  mem_write    in   1   1 = store, 0 = load; sampled with req
//  addr_in      in   32  byte address from core
//  wdata_in     in   32  store data from core
//  rdata_out    out  32  load data; valid only while ready=1
//  ready        out  1   one-cycle pulse: transaction complete
//  error        out  1   valid with ready: misaligned or out-of-range access
// BEHAVIOUR
//  - Reset: state=IDLE, wait counter=0, rdata_out=0, ready=0, error=0. RAM contents NOT cleared.
//  - FSM IDLE -> WAIT -> DONE -> IDLE.
//    IDLE: if req at edge, latch addr_in/wdata_in/mem_write; go WAIT, counter=WAIT_CYCLES
//          (WAIT_CYCLES=0: go straight to DONE). No req: stay.
//    WAIT: counter decrements each edge; at counter==1 go DONE. Inputs ignored.
//    DONE: ready=1 for exactly this cycle; next edge returns to IDLE unconditionally.
//  - Latency: request accepted at edge N -> ready high in cycle N+1+WAIT_CYCLES.
//    Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
//  - Store: RAM word written on the edge entering DONE using latched data; never earlier.
//  - Load: rdata_out registered on the edge entering DONE from RAM[latched addr]; 0 outside DONE.
//  - Word index = addr[DEPTH_LOG2+1:2].
//  - error is set when either:
//      addr[1:0] != 0, or addr[31:DEPTH_LOG2+2] != 0.
//    Then no RAM write occurs, rdata_out=0, and error=1 alongside ready. Transaction still completes.
//  - Changes to req/addr/wdata after acceptance have no effect. A req still high in the cycle after
//    ready (back in IDLE) is a NEW transaction.
//  - Reset mid-transaction (WAIT or DONE): return to IDLE next edge, pending store discarded,
//    ready/error low next cycle.
//  - Load of a word written by the immediately preceding store returns the new data.
// CONFIGURATION
//  - DMEM_DEBUG_EN defined: adds input debug_mem_addr [DEPTH_LOG2-1:0] and output
//    debug_mem_data [31:0]. The output is an asynchronous read of RAM[debug_mem_addr], independent
//    of the FSM, and is used by the board debug display alongside the register debug port.
//  - DMEM_DEBUG_EN undefined: both ports are absent; the functional behaviour is otherwise identical.
// TESTING
//  1. WAIT_CYCLES=2: store 0xDEADBEEF to 0x10 with req at edge 0 -> ready=1, error=0 in cycle 3.
//     Then load from 0x10 -> rdata_out=0xDEADBEEF in its ready cycle.
//  2. WAIT_CYCLES=0: load from 0x04 after a store of 0x12345678 -> ready exactly 1 cycle after
//     acceptance, rdata=0x12345678.
//  3. Load from 0x13 (misaligned) and from 0x400 (out of range, DEPTH_LOG2=8) -> ready+error=1,
//     rdata=0. A store to 0x400 leaves word 0 unchanged.
//  4. Store 0xAAAA5555 to 0x20, assert rst during WAIT -> FSM back in IDLE, ready never pulses,
//     later load of 0x20 returns its old value.
//  5. Hold req high for 3 back-to-back loads with changing addr_in -> each ready pulse is
//     WAIT_CYCLES+2 apart; each rdata matches the addr_in present at its acceptance edge.
//  6. DMEM_DEBUG_EN: after store 0xCAFEF00D to 0x08, debug_mem_addr=2 -> debug_mem_data=0xCAFEF00D
//     in the same cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-RAM responder for the core data port with programmable wait states.
// Optional macro DMEM_DEBUG_EN adds an asynchronous debug read port (debug_mem_addr/debug_mem_data).
module dmem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        mem_write,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic [31:0] rdata_out,
    output logic        ready,
    output logic        error
`ifdef DMEM_DEBUG_EN
    ,
    input  logic [DEPTH_LOG2-1:0] debug_mem_addr,
    output logic [31:0]           debug_mem_data
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [31:0] addr_q, data_q;
    logic write_q;
    logic [31:0] mem [2**DEPTH_LOG2];
    logic in_idle, accept, go_done;
    logic [31:0] cur_addr, cur_data;
    logic cur_write, cur_err;
    logic [DEPTH_LOG2-1:0] idx;

    // With zero wait states the transaction completes on its acceptance edge,
    // so the live inputs are used in IDLE and the latched copies otherwise.
    assign in_idle   = state == IDLE;
    assign accept    = in_idle && req;
    assign cur_addr  = in_idle ? addr_in : addr_q;
    assign cur_data  = in_idle ? wdata_in : data_q;
    assign cur_write = in_idle ? mem_write : write_q;
    assign cur_err   = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign idx       = cur_addr[DEPTH_LOG2+1:2];
    assign go_done   = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1);
    assign ready     = state == DONE;

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: IDLE -> WAIT -> DONE -> IDLE, skipping WAIT when there are no wait states
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (go_done) begin
            state_nxt = DONE;
            cnt_nxt   = 4'd0;
        end else if (accept) begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES);
        end else if (state == WAIT) begin
            cnt_nxt = cnt - 4'd1;
        end else if (state != IDLE) begin
            state_nxt = IDLE;
        end
    end

    // Request latch and registered response, valid only for the DONE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            write_q   <= 1'b0;
            rdata_out <= 32'd0;
            error     <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= addr_in;
                data_q  <= wdata_in;
                write_q <= mem_write;
            end
            rdata_out <= (go_done && !cur_write && !cur_err) ? mem[idx] : 32'd0;
            error     <= go_done && cur_err;
        end
    end

    // Store commits only on the edge entering DONE; a reset on that edge discards it
    always_ff @(posedge clk) begin
        if (!rst && go_done && cur_write && !cur_err)
            mem[idx] <= cur_data;
    end

`ifdef DMEM_DEBUG_EN
    assign debug_mem_data = mem[debug_mem_addr];
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: transaction-level model check of two dmem_responder instances (2 and 0 wait states).
module tb_dmem_responder;
    localparam int W0 = 2;
    localparam int W1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v, req_v, wr_v;
    logic [1:0][31:0] addr_v, wd_v;
    logic rdy0, rdy1, err0, err1;
    logic [31:0] rd0, rd1;
    logic [1:0] rdy_v, err_v;
    logic [1:0][31:0] rd_v;
    assign rdy_v = {rdy1, rdy0};
    assign err_v = {err1, err0};
    assign rd_v  = {rd1, rd0};
`ifdef DMEM_DEBUG_EN
    logic [7:0] dbg_a0, dbg_a1;
    logic [31:0] dbg_d0, dbg_d1;
`endif

    int checks = 0;
    int errors = 0;
    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(W0)) u_w2 (
        .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .mem_write(wr_v[0]),
        .addr_in(addr_v[0]), .wdata_in(wd_v[0]),
        .rdata_out(rd0), .ready(rdy0), .error(err0)
`ifdef DMEM_DEBUG_EN
        , .debug_mem_addr(dbg_a0), .debug_mem_data(dbg_d0)
`endif
    );

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(W1)) u_w0 (
        .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .mem_write(wr_v[1]),
        .addr_in(addr_v[1]), .wdata_in(wd_v[1]),
        .rdata_out(rd1), .ready(rdy1), .error(err1)
`ifdef DMEM_DEBUG_EN
        , .debug_mem_addr(dbg_a1), .debug_mem_data(dbg_d1)
`endif
    );

    // Transaction model: a request seen while free is taken, completes WAIT cycles
    // later, and the responder is free again two edges after completion.
    logic [31:0] mm [2][256];
    bit pend [2];
    int done_e [2];
    int idle_at [2];
    logic [31:0] la [2];
    logic [31:0] ld [2];
    logic lw [2];
    logic e_rdy [2];
    logic e_err [2];
    logic [31:0] e_rd [2];

    function automatic int wait_of(input int d);
        return d == 0 ? W0 : W1;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            pend[d] = 0; idle_at[d] = 0; done_e[d] = 0;
            e_rdy[d] = 0; e_err[d] = 0; e_rd[d] = 0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (edges > 0) begin
                checks++;
                if (rdy_v[d] !== e_rdy[d] || err_v[d] !== e_err[d] || rd_v[d] !== e_rd[d]) begin
                    errors++;
                    $display("FAIL cycle dut%0d edge%0d: got rdy=%b err=%b rd=%h expected rdy=%b err=%b rd=%h",
                             d, edges - 1, rdy_v[d], err_v[d], rd_v[d], e_rdy[d], e_err[d], e_rd[d]);
                end
            end
            e_rdy[d] = 0; e_err[d] = 0; e_rd[d] = 32'd0;
            if (rst_v[d]) begin
                pend[d] = 0;
                idle_at[d] = edges + 1;
            end else begin
                if (!pend[d] && edges >= idle_at[d] && req_v[d]) begin
                    pend[d] = 1;
                    la[d] = addr_v[d]; ld[d] = wd_v[d]; lw[d] = wr_v[d];
                    done_e[d] = edges + wait_of(d);
                end
                if (pend[d] && done_e[d] == edges) begin
                    e_rdy[d] = 1;
                    e_err[d] = (la[d][1:0] != 2'b00) || (la[d] >= 32'h400);
                    if (!e_err[d]) begin
                        if (lw[d]) mm[d][la[d][9:2]] = ld[d];
                        else e_rd[d] = mm[d][la[d][9:2]];
                    end
                    pend[d] = 0;
                    idle_at[d] = edges + 2;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wait_rdy(input int d, output int e);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!rdy_v[d] && n < 40);
        checks++;
        if (!rdy_v[d]) begin
            errors++;
            $display("FAIL timeout dut%0d: got no ready expected ready within 40 cycles", d);
        end
        e = edges - 1;
    endtask

    // One transaction; inputs are scrambled after acceptance to show they are ignored
    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] dat,
                       output logic [31:0] rd, output logic er, output int lat);
        int acc, e;
        @(posedge clk); #1;
        req_v[d] = 1'b1; wr_v[d] = w; addr_v[d] = a; wd_v[d] = dat;
        acc = edges;
        @(posedge clk); #1;
        addr_v[d] = ~a; wd_v[d] = ~dat; wr_v[d] = ~w;
        wait_rdy(d, e);
        rd = rd_v[d]; er = err_v[d]; lat = e - acc;
        @(posedge clk); #1;
        req_v[d] = 1'b0;
    endtask

    logic [31:0] rd;
    logic er;
    int lat, n;
    int re [3];
    logic [31:0] rdd [3];
    logic [31:0] ta [3];

    initial begin
        ta[0] = 32'h10; ta[1] = 32'h20; ta[2] = 32'h0;
        rst_v = 2'b11; req_v = '0; wr_v = '0; addr_v = '0; wd_v = '0;
`ifdef DMEM_DEBUG_EN
        dbg_a0 = '0; dbg_a1 = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {30'd0, rdy_v}, 32'd0);
        chk("reset_error", {30'd0, err_v}, 32'd0);
        chk("reset_rdata", rd0 | rd1, 32'd0);
        @(posedge clk); #1;
        rst_v = 2'b00;

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        chk("t1_store_err", {31'd0, er}, 32'd0);
        chk("t1_store_latency", lat, 32'd2);
        txn(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("t1_load_rdata", rd, 32'hDEADBEEF);

        txn(1, 1'b1, 32'h04, 32'h12345678, rd, er, lat);
        txn(1, 1'b0, 32'h04, 32'h0, rd, er, lat);
        chk("t2_latency", lat, 32'd0);
        chk("t2_load_rdata", rd, 32'h12345678);
        txn(1, 1'b0, 32'h402, 32'h0, rd, er, lat);
        chk("t2_misaligned_err", {31'd0, er}, 32'd1);

        txn(0, 1'b1, 32'h0, 32'h0BADF00D, rd, er, lat);
        txn(0, 1'b0, 32'h13, 32'h0, rd, er, lat);
        chk("t3_misaligned_err", {31'd0, er}, 32'd1);
        chk("t3_misaligned_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h400, 32'h0, rd, er, lat);
        chk("t3_range_err", {31'd0, er}, 32'd1);
        chk("t3_range_rdata", rd, 32'd0);
        txn(0, 1'b1, 32'h400, 32'hFFFFFFFF, rd, er, lat);
        chk("t3_range_store_err", {31'd0, er}, 32'd1);
        txn(0, 1'b0, 32'h0, 32'h0, rd, er, lat);
        chk("t3_word0_kept", rd, 32'h0BADF00D);

        txn(0, 1'b1, 32'h20, 32'h11112222, rd, er, lat);
        @(posedge clk); #1;
        req_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 32'h20; wd_v[0] = 32'hAAAA5555;
        @(posedge clk); #1;
        req_v[0] = 1'b0; rst_v[0] = 1'b1;
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        n = 0;
        repeat (8) begin @(negedge clk); if (rdy_v[0]) n++; end
        chk("t4_no_ready", n, 32'd0);
        txn(0, 1'b0, 32'h20, 32'h0, rd, er, lat);
        chk("t4_old_value", rd, 32'h11112222);

        @(posedge clk); #1;
        req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = ta[0];
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (k < 2) addr_v[0] = ta[k+1];
            wait_rdy(0, re[k]);
            rdd[k] = rd_v[0];
            @(posedge clk);
        end
        #1 req_v[0] = 1'b0;
        chk("t5_gap1", re[1] - re[0], 32'd4);
        chk("t5_gap2", re[2] - re[1], 32'd4);
        chk("t5_rdata0", rdd[0], 32'hDEADBEEF);
        chk("t5_rdata1", rdd[1], 32'h11112222);
        chk("t5_rdata2", rdd[2], 32'h0BADF00D);

`ifdef DMEM_DEBUG_EN
        txn(0, 1'b1, 32'h08, 32'hCAFEF00D, rd, er, lat);
        dbg_a0 = 8'd2;
        #1;
        chk("t6_debug_data", dbg_d0, 32'hCAFEF00D);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
